// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants and the input operation enum for the instruction encoder.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        OpAdd     = 3'd0,
        OpSub     = 3'd1,
        OpAnd     = 3'd2,
        OpOr      = 3'd3,
        OpLd      = 3'd4,
        OpSd      = 3'd5,
        OpBeq     = 3'd6,
        OpIllegal = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_DOUBLE  = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // True when the 64-bit immediate is representable as a signed 12-bit value.
    function automatic logic imm_fits12(input logic [63:0] imm);
        return imm[63:11] == {53{imm[11]}};
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer for RV64 words.
// INSTR_ENC_RANGE_CHECK_EN: reject ld/sd/beq immediates that do not fit signed 12 bits.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    logic [11:0] i;
    assign i = imm[11:0];

`ifndef INSTR_ENC_RANGE_CHECK_EN
    logic unused_imm;
    assign unused_imm = ^imm[63:12];
`endif

    always_comb begin
        instr = '0;
        legal = 1'b1;
        unique case (op)
            OpAdd:     instr = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
            OpSub:     instr = {F7_SUB, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
            OpAnd:     instr = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OpOr:      instr = {F7_BASE, rs2, rs1, F3_OR, rd, OPC_OP};
            OpLd:      instr = {i, rs1, F3_DOUBLE, rd, OPC_LOAD};
            OpSd:      instr = {i[11:5], rs2, rs1, F3_DOUBLE, i[4:0], OPC_STORE};
            // Branch field holds the decoder's raw 12-bit value, not a byte offset.
            OpBeq:     instr = {i[11], i[9:4], rs2, rs1, F3_BEQ, i[3:0], i[10], OPC_BRANCH};
            OpIllegal: legal = 1'b0;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if ((op == OpLd || op == OpSd || op == OpBeq) && !imm_fits12(imm)) begin
            legal = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs field bundles into words and writes them to imem
// at an auto-incrementing address through a one-entry output register.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [63:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [31:0]   out_instr,
    output logic          err,
    output logic          done,
    output logic [AW-2:0] count
);

    state_e      state;
    logic        accept;
    logic        wr;
    logic [31:0] pack_instr;
    logic        pack_legal;
    logic        unused_base;

    assign unused_base = ^base_addr[1:0];

    assign in_ready = (state == StRun) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign wr       = out_valid && out_ready;

    instr_pack u_pack (
        .op    (op_e'(in_op)),
        .rd    (in_rd),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .imm   (in_imm),
        .instr (pack_instr),
        .legal (pack_legal)
    );

    // out_addr always names the address of the word currently held (or the next one to come).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_instr <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            err  <= accept && !pack_legal;
            done <= 1'b0;

            if (wr) begin
                out_addr <= out_addr + AW'(4);
                count    <= count + 1'b1;
            end

            if (accept && pack_legal) begin
                out_valid <= 1'b1;
                out_instr <= pack_instr;
            end else if (wr) begin
                out_valid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StRun;
                        out_addr <= {base_addr[AW-1:2], 2'b00};
                        count    <= '0;
                    end
                end
                StRun: begin
                    if (finish) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (!out_valid) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized stream
// compared against an arithmetic reference encoder and a write scoreboard.
module tb_instr_encoder;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, finish, in_valid, out_ready;
    logic [AW-1:0] base_addr;
    logic [2:0]    in_op;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [63:0]   in_imm;
    logic          in_ready, out_valid, err, done;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_instr;
    logic [AW-2:0] count;

    // Narrow instance for address wrap.
    logic        s_rst, s_start, s_finish, s_in_valid, s_out_ready;
    logic [3:0]  s_base;
    logic        s_in_ready, s_out_valid, s_err, s_done;
    logic [3:0]  s_out_addr;
    logic [31:0] s_out_instr;
    logic [2:0]  s_count;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_instr(out_instr), .err(err),
        .done(done), .count(count)
    );

    instr_encoder #(.AW(4)) dut_small (
        .clk(clk), .rst(s_rst), .start(s_start), .finish(s_finish), .base_addr(s_base),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_addr(s_out_addr), .out_instr(s_out_instr), .err(s_err),
        .done(s_done), .count(s_count)
    );

    // Reference encoder built from field positions with plain arithmetic.
    function automatic void ref_encode(input int unsigned op, input int unsigned rd,
                                       input int unsigned rs1, input int unsigned rs2,
                                       input logic [63:0] imm, output bit ok,
                                       output logic [31:0] w);
        int unsigned i12, regs;
        i12  = int'(imm % 64'd4096);
        regs = (rs2 << 20) + (rs1 << 15) + (rd << 7);
        ok   = 1'b1;
        w    = '0;
        case (op)
            0: w = regs + 32'h33;
            1: w = (32 << 25) + regs + 32'h33;
            2: w = regs + (7 << 12) + 32'h33;
            3: w = regs + (6 << 12) + 32'h33;
            4: w = (i12 << 20) + (rs1 << 15) + (3 << 12) + (rd << 7) + 3;
            5: w = ((i12 / 32) << 25) + (rs2 << 20) + (rs1 << 15) + (3 << 12)
                   + ((i12 % 32) << 7) + 35;
            6: w = ((i12 / 2048) << 31) + (((i12 / 16) % 64) << 25) + (rs2 << 20)
                   + (rs1 << 15) + ((i12 % 16) << 8) + (((i12 / 1024) % 2) << 7) + 99;
            default: ok = 1'b0;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        begin
            longint s;
            s = $signed(imm);
            if (op >= 4 && op <= 6 && (s < -2048 || s > 2047)) ok = 1'b0;
        end
`endif
    endfunction

    // What the ID stage reconstructs from a branch word.
    function automatic logic [63:0] ref_branch_imm(input logic [31:0] w);
        int unsigned raw;
        longint v;
        raw = ((w >> 31) & 1) * 2048 + ((w >> 7) & 1) * 1024 + ((w >> 25) & 63) * 16
              + ((w >> 8) & 15);
        v = (raw >= 2048) ? longint'(raw) - 4096 : longint'(raw);
        return v;
    endfunction

    task automatic set_bundle(input logic v, input logic [2:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [63:0] imm);
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic reset_and_start(input logic [AW-1:0] b);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; finish = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; finish = 1'b1; out_ready = 1'b1;
        set_bundle(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 64'd5);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_addr !== '0) begin n_bad++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
        n_cmp++; if (out_instr !== '0) begin n_bad++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        n_cmp++; if ({err, done} !== 2'b00) begin n_bad++; $display("FAIL reset_err_done: got %b want 00", {err, done}); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_add();
        reset_and_start(10'h100);
        n_cmp++; if (out_addr !== 10'h100) begin n_bad++; $display("FAIL start_addr: got %h want 100", out_addr); end
        set_bundle(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 64'hDEAD);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_instr !== 32'h002081B3) begin n_bad++; $display("FAIL add_instr: got %h want 002081b3", out_instr); end
        n_cmp++; if (out_addr !== 10'h100) begin n_bad++; $display("FAIL add_addr: got %h want 100", out_addr); end
        @(negedge clk);
        n_cmp++; if (count !== 9'd1) begin n_bad++; $display("FAIL add_count: got %0d want 1", count); end
        n_cmp++; if (out_addr !== 10'h104) begin n_bad++; $display("FAIL add_next_addr: got %h want 104", out_addr); end
    endtask

    task automatic test_back_to_back();
        reset_and_start(10'h100);
        set_bundle(1'b1, 3'd4, 5'd5, 5'd10, 5'd0, 64'd8);
        @(negedge clk);
        set_bundle(1'b1, 3'd5, 5'd0, 5'd2, 5'd6, -64'sd16);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_instr !== 32'h00853283) begin n_bad++; $display("FAIL ld_instr: got %h want 00853283", out_instr); end
        n_cmp++; if (out_addr !== 10'h100) begin n_bad++; $display("FAIL ld_addr: got %h want 100", out_addr); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sd_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_instr !== 32'hFE613823) begin n_bad++; $display("FAIL sd_instr: got %h want fe613823", out_instr); end
        n_cmp++; if (out_addr !== 10'h104) begin n_bad++; $display("FAIL sd_addr: got %h want 104", out_addr); end
        @(negedge clk);
        n_cmp++; if (count !== 9'd2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", count); end
    endtask

    task automatic test_beq();
        reset_and_start(10'h040);
        set_bundle(1'b1, 3'd6, 5'd0, 5'd1, 5'd2, -64'sd2);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== 32'hFE208EE3) begin n_bad++; $display("FAIL beq_instr: got %h want fe208ee3", out_instr); end
        n_cmp++; if (ref_branch_imm(out_instr) !== 64'hFFFFFFFFFFFFFFFE) begin
            n_bad++; $display("FAIL beq_decode: got %h want fffffffffffffffe", ref_branch_imm(out_instr));
        end
    endtask

    task automatic test_backpressure();
        reset_and_start(10'h200);
        set_bundle(1'b1, 3'd2, 5'd7, 5'd8, 5'd9, 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        set_bundle(1'b1, 3'd3, 5'd11, 5'd12, 5'd13, 64'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", k, in_ready); end
            @(negedge clk);
            n_cmp++; if (out_instr !== 32'h009473B3 || out_addr !== 10'h200) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got %h@%h want 009473b3@200", k, out_instr, out_addr);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== 32'h00D665B3 || out_addr !== 10'h204) begin
            n_bad++; $display("FAIL bp_second: got %h@%h want 00d665b3@204", out_instr, out_addr);
        end
        @(negedge clk);
        n_cmp++; if (count !== 9'd2 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_count: got %0d/%b want 2/0", count, out_valid);
        end
    endtask

    task automatic test_reject();
        reset_and_start(10'h300);
        set_bundle(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (err !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL illegal_err: got err=%b valid=%b want 1/0", err, out_valid);
        end
        @(negedge clk);
        n_cmp++; if (err !== 1'b0 || out_addr !== 10'h300 || count !== 9'd0) begin
            n_bad++; $display("FAIL illegal_after: got err=%b addr=%h cnt=%0d want 0/300/0", err, out_addr, count);
        end
        set_bundle(1'b1, 3'd4, 5'd5, 5'd10, 5'd0, 64'd2048);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        n_cmp++; if (err !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL range_err: got err=%b valid=%b want 1/0", err, out_valid);
        end
        @(negedge clk);
        n_cmp++; if (out_addr !== 10'h300 || count !== 9'd0) begin
            n_bad++; $display("FAIL range_after: got addr=%h cnt=%0d want 300/0", out_addr, count);
        end
`else
        n_cmp++; if (err !== 1'b0 || out_instr !== 32'h80053283 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL trunc_ld: got err=%b %h valid=%b want 0/80053283/1", err, out_instr, out_valid);
        end
`endif
    endtask

    task automatic test_finish_done();
        reset_and_start(10'h010);
        set_bundle(1'b1, 3'd1, 5'd4, 5'd5, 5'd6, 64'd0);
        finish = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; finish = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h40628233 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL fin_word: got valid=%b %h ready=%b want 1/40628233/0", out_valid, out_instr, in_ready);
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || count !== 9'd1) begin
            n_bad++; $display("FAIL fin_write: got done=%b cnt=%0d want 0/1", done, count);
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fin_done: got %b want 1", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL fin_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_reset_mid_run();
        reset_and_start(10'h080);
        out_ready = 1'b0;
        set_bundle(1'b1, 3'd0, 5'd1, 5'd1, 5'd1, 64'd0);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got %b want 1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if ({out_valid, err, done, in_ready} !== 4'b0 || out_addr !== '0 || out_instr !== '0
                     || count !== '0) begin
            n_bad++; $display("FAIL mid_reset: got v/e/d/r=%b addr=%h instr=%h cnt=%0d want all 0",
                              {out_valid, err, done, in_ready}, out_addr, out_instr, count);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_wrap_small();
        @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0; s_start = 1'b1; s_base = 4'hC; s_out_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0; s_in_valid = 1'b1;
        in_op = 3'd0; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 64'd0;
        @(negedge clk);
        n_cmp++; if (s_out_addr !== 4'hC || s_out_instr !== 32'h002081B3) begin
            n_bad++; $display("FAIL wrap_first: got %h@%h want 002081b3@c", s_out_instr, s_out_addr);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        n_cmp++; if (s_out_addr !== 4'h0 || s_count !== 3'd1 || s_out_valid !== 1'b1) begin
            n_bad++; $display("FAIL wrap_second: got addr=%h cnt=%0d v=%b want 0/1/1", s_out_addr, s_count, s_out_valid);
        end
        @(negedge clk);
        n_cmp++; if (s_count !== 3'd2 || s_out_addr !== 4'h4 || s_err !== 1'b0) begin
            n_bad++; $display("FAIL wrap_end: got cnt=%0d addr=%h err=%b want 2/4/0", s_count, s_out_addr, s_err);
        end
    endtask

    task automatic test_random_stream();
        logic [31:0]   exp_q[$];
        logic [AW-1:0] m_addr;
        logic [AW-2:0] m_count;
        logic [AW-1:0] b;
        logic          exp_err;
        logic          exp_ready;
        bit            ok;
        logic [31:0]   w;
        logic [11:0]   r12;
        b = AW'($urandom);
        reset_and_start(b);
        m_addr  = {b[AW-1:2], 2'b00};
        m_count = '0;
        exp_err = 1'b0;
        for (int k = 0; k < 420; k++) begin
            if (k != 0) @(negedge clk);
            n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", k, err, exp_err); end
            n_cmp++; if (out_valid !== (exp_q.size() != 0)) begin
                n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, out_valid, exp_q.size() != 0);
            end
            out_ready = (k < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            r12 = 12'($urandom);
            set_bundle((k < 400) ? ($urandom_range(0, 2) != 0) : 1'b0, 3'($urandom_range(0, 7)),
                       5'($urandom), 5'($urandom), 5'($urandom),
                       ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : {{52{r12[11]}}, r12});
            #1;
            exp_ready = (exp_q.size() == 0) || out_ready;
            n_cmp++; if (in_ready !== exp_ready) begin
                n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, in_ready, exp_ready);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                n_cmp++; if (out_instr !== w || out_addr !== m_addr) begin
                    n_bad++; $display("FAIL rnd_write[%0d]: got %h@%h want %h@%h", k, out_instr, out_addr, w, m_addr);
                end
                m_addr  = m_addr + AW'(4);
                m_count = m_count + 1'b1;
            end
            exp_err = 1'b0;
            if (in_valid && exp_ready) begin
                ref_encode(in_op, in_rd, in_rs1, in_rs2, in_imm, ok, w);
                if (ok) exp_q.push_back(w);
                else exp_err = 1'b1;
            end
        end
        n_cmp++; if (count !== m_count || exp_q.size() != 0) begin
            n_bad++; $display("FAIL rnd_count: got %0d want %0d (left %0d)", count, m_count, exp_q.size());
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        base_addr = '0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        s_rst = 1'b1; s_start = 1'b0; s_finish = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        s_base = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_beq();
        test_backpressure();
        test_reject();
        test_finish_done();
        test_reset_mid_run();
        test_wrap_small();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
